// File: rtl/shift_seq_pkg.sv
// Shared mode and state encodings for the
// sequenced shift register.
package shift_seq_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_LSL = 3'b000;
  localparam mode_t MODE_LSR = 3'b001;
  localparam mode_t MODE_ASR = 3'b010;
  localparam mode_t MODE_ROL = 3'b011;
  localparam mode_t MODE_ROR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step_unit.sv
// One-position shifter shared by the single-step
// and the auto-sequence paths.
module shift_step_unit
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  mode_t            i_mode,
  input  logic             i_ser_in,
  output logic [WIDTH-1:0] o_next_q,
  output logic             o_out_bit,
  output logic             o_valid
);

  always_comb begin
    o_next_q  = i_q;
    o_out_bit = 1'b0;
    o_valid   = 1'b1;
    unique case (i_mode)
      MODE_LSL: begin
        o_next_q  = {i_q[WIDTH-2:0], i_ser_in};
        o_out_bit = i_q[WIDTH-1];
      end
      MODE_LSR: begin
        o_next_q  = {i_ser_in, i_q[WIDTH-1:1]};
        o_out_bit = i_q[0];
      end
      MODE_ASR: begin
        o_next_q  = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
        o_out_bit = i_q[0];
      end
      MODE_ROL: begin
        o_next_q  = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
        o_out_bit = i_q[WIDTH-1];
      end
      MODE_ROR: begin
        o_next_q  = {i_q[0], i_q[WIDTH-1:1]};
        o_out_bit = i_q[0];
      end
      // Reserved encodings hold q and ser_out.
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/shift_seq_unit.sv
// WIDTH-bit shift register with parallel load,
// single-step shifts and a counted auto-sequencer.
module shift_seq_unit
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_n,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic [CNT_W-1:0] shamt,
  input  logic [2:0]       mode,
  input  logic             step,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           r_state;
  mode_t            r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic             r_ser_out;
  logic             r_busy;
  logic             r_done;

  mode_t            w_mode;
  logic [WIDTH-1:0] w_next_q;
  logic             w_out_bit;
  logic             w_valid;

  // The sequencer uses the mode latched at start.
  assign w_mode = (r_state == ST_SHIFT) ? r_mode : mode;

  shift_step_unit #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_q      (r_q),
    .i_mode   (w_mode),
    .i_ser_in (ser_in),
    .o_next_q (w_next_q),
    .o_out_bit(w_out_bit),
    .o_valid  (w_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_mode    <= MODE_LSL;
      r_cnt     <= CNT_ZERO;
      r_q       <= '0;
      r_ser_out <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_SHIFT: begin
          if (w_valid) begin
            r_q       <= w_next_q;
            r_ser_out <= w_out_bit;
          end
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          if (!load_n) begin
            r_q <= load_val;
          end else if (start) begin
            if (shamt != CNT_ZERO) begin
              r_mode  <= mode;
              r_cnt   <= shamt;
              r_state <= ST_SHIFT;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end else if (step && w_valid) begin
            r_q       <= w_next_q;
            r_ser_out <= w_out_bit;
          end
        end
      endcase
    end
  end

  assign q       = r_q;
  assign ser_out = r_ser_out;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: doc/shift_seq_unit.md
Name: shift_seq_unit

Overview:
- Parametrised successor to the single-bit load/shift cell: a WIDTH-bit shift register with parallel load, five shift/rotate modes, a serial in/out path, and an auto-sequencer.
- The sequencer performs a multi-position shift at one position per clock and signals completion with a busy/done handshake.
- It sits in datapaths that need a serialiser, bit-stream generator or sequential shifter. A single-step mode preserves the original one-shift-per-cycle use.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- CNT_W, 4, width of the shift-amount port; maximum sequence length is 2^CNT_W - 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- load_n  input  1  active-low parallel load strobe.
- load_val  input  WIDTH  parallel load data.
- start  input  1  begin an auto-sequence of shamt shifts.
- shamt  input  CNT_W  number of single-position shifts to perform.
- mode  input  3  shift mode (see Behaviour).
- step  input  1  single shift this cycle, idle only.
- ser_in  input  1  serial fill bit for logical modes.
- q  output  WIDTH  register contents.
- ser_out  output  1  registered copy of the last bit shifted or rotated out.
- busy  output  1  high while the sequencer is shifting.
- done  output  1  one-cycle pulse when a sequence completes.

Behaviour:
- Reset (async, reset_n=0): q=0, ser_out=0, busy=0, done=0, state=IDLE, counter=0. Takes effect immediately without a clock edge, including mid-sequence; any sequence in progress is aborted with no done pulse.
- Mode encoding:
  - 000 LSL: q <= {q[W-2:0], ser_in}; out bit = q[W-1].
  - 001 LSR: q <= {ser_in, q[W-1:1]}; out bit = q[0].
  - 010 ASR: MSB replicated; out bit = q[0].
  - 011 ROL: out bit = q[W-1], which also wraps into bit 0.
  - 100 ROR: out bit = q[0], which also wraps into the MSB.
  - 101-111 reserved: q and ser_out hold; a sequence still counts down and completes normally.
- States:
  - IDLE: accepts commands.
  - SHIFT: busy=1.
  - DONE: done=1 for exactly one cycle; accepts commands exactly as IDLE does.
- Command priority in IDLE/DONE, highest first: load_n=0, then start, then step.
  - load_n=0: q <= load_val; ser_out unchanged; start and step ignored that cycle.
  - start with shamt=N>0: mode is latched, counter <= N, go to SHIFT.
  - start with shamt=0: go to DONE; q is unchanged.
  - step: one shift in the current mode; ser_out updated; no done pulse.
- SHIFT:
  - Every edge: one shift using the latched mode and the live ser_in; ser_out <= out bit; counter decrements.
  - The edge at which counter==1 moves the state to DONE.
  - load_n, start and step are ignored while in SHIFT.
- Latency:
  - start sampled at edge t gives shifts at edges t+1..t+N.
  - busy is high for N cycles; done is high during the cycle after edge t+N.
  - Back-to-back start in DONE is allowed.
- Rotations wrap modulo WIDTH naturally, so shamt > WIDTH is legal; logical shifts with shamt >= WIDTH fill q entirely with ser_in history.
- All outputs are registered; no combinational input-to-output path.

Decomposition:
- Package shift_seq_pkg:
  - mode constants MODE_LSL, MODE_LSR, MODE_ASR, MODE_ROL, MODE_ROR;
  - state encoding ST_IDLE, ST_SHIFT, ST_DONE.
- Sub-module shift_step_unit: combinational one-position shifter (q, mode, ser_in -> next_q, out_bit), shared by the step and sequencer paths.

Test Plan (WIDTH=8, CNT_W=4):
- LSL sequence: load 0xB5; start, mode=000, shamt=3, ser_in=0 -> busy high 3 cycles, q=0x6A, 0xD4, 0xA8; ser_out=1; then done pulses once and busy=0.
- ASR sequence: load 0x90; start, mode=010, shamt=2 -> q=0xC8 then 0xE4, ser_out=0, done after 2 shifts.
- ROR wrap: load 0x81; start, mode=100, shamt=9 -> q=0xC0, ser_out=1, busy 9 cycles.
- Zero amount and priority: start with shamt=0 -> done next cycle, q unchanged. load_n=0 with start=1 together -> q=load_val, no sequence. load_n=0 while busy -> ignored.
- Async reset mid-sequence: reset_n=0 during SHIFT between clock edges -> q=0x00, busy=0, done=0 immediately; no done pulse after release.
- Single step: q=0x00; step, mode=001, ser_in=1 -> q=0x80, ser_out=0, done stays 0. Then mode=101 with step -> q holds 0x80.
